program_loader: RTL
===================

Name: program_loader

Overview:
- Boot-time stage directly upstream of the multi-cycle processor.
- Accepts a stream of 16-bit program/data words over a valid/ready handshake and writes them into the processor's unified memory through a dedicated write port.
- Holds the processor in reset while loading, then releases it after a programmable hold time.
- Keeps a running 16-bit checksum of the loaded image for the bench and for debug.

Parameters:
- DATA_W, 16, memory word width; matches processor data/instruction width.
- ADDR_W, 12, memory address width; matches the 12-bit address field of instructions.
- BASE_ADDR, 0, first memory address written by a load.
- RST_HOLD, 4, cycles the processor reset stays asserted after the last write (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle request to begin a load.
- load_len  input  ADDR_W+1  word count, sampled when load_start is accepted; range 0..2^ADDR_W.
- in_valid  input  1  in_data holds a word.
- in_data  input  DATA_W  program word.
- in_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory write address.
- mem_wdata  output  DATA_W  memory write data.
- cpu_rst  output  1  active-high reset to the processor.
- running  output  1  processor released and executing.
- busy  output  1  load or reset-hold in progress.
- checksum  output  DATA_W  mod-2^16 sum of the words of the current/last load.

Behaviour:
- Async reset (rst=0):
  - State IDLE.
  - cpu_rst=1.
  - All other outputs 0.
  - Counters and checksum cleared.
- States: IDLE, LOAD, HOLD, RUN. Encoding constants live in the package.
- IDLE:
  - cpu_rst=1, in_ready=0.
  - On load_start, latch len=load_len, clear count and checksum.
  - Next state is LOAD, or HOLD if len=0.
- LOAD:
  - busy=1, cpu_rst=1.
  - in_ready=1 while count<len.
  - A word is accepted on the cycle where in_valid&in_ready.
  - Write latency is one cycle. The cycle after acceptance: mem_we=1, mem_addr=(BASE_ADDR+count_at_accept) mod 2^ADDR_W, mem_wdata=the accepted word.
  - Back-to-back accepts produce back-to-back writes.
  - checksum updates in the same cycle mem_we is asserted.
  - Addresses wrap past 2^ADDR_W-1 to 0 with no error.
  - After the write of the len-th word, go to HOLD with hold counter=RST_HOLD.
  - in_ready drops to 0 in the cycle after the final accept.
  - load_start is ignored in LOAD and HOLD.
- HOLD:
  - busy=1, cpu_rst=1, no writes.
  - The counter decrements each cycle.
  - When it reaches 0, go to RUN: cpu_rst=0, running=1, busy=0 in that first RUN cycle.
  - The processor therefore sees exactly RUN_HOLD... precisely, reset stays asserted for RST_HOLD cycles after the final mem_we cycle.
- RUN:
  - cpu_rst=0, running=1.
  - load_start reloads. In the next cycle cpu_rst=1, running=0, and the state is LOAD (or HOLD if len=0) with count and checksum cleared.
  - No memory write occurs in the transition cycle.
- in_valid without in_ready (IDLE/HOLD/RUN, or count==len): the word is not consumed and no write occurs.
- Async reset mid-load: outputs return to reset values immediately. A partially loaded image is abandoned and the next load restarts at BASE_ADDR.
- mem_we is never asserted outside LOAD or the cycle immediately after the final accept.
- Checksum arithmetic: DATA_W-bit, carry discarded.

Decomposition:
- Package program_loader_pkg:
  - State typedef/encodings (IDLE, LOAD, HOLD, RUN).
  - DATA_W and ADDR_W defaults.
- Optional sub-module: loader_write_stage. It holds the one-cycle registered write pipeline (addr/data/we registers plus checksum accumulator). The FSM and counters stay in program_loader.

Test Plan:
- Reset then load_start with load_len=3, words 0x1234, 0x0001, 0xFFFF streamed with in_valid always 1:
  - Writes to addresses 0, 1, 2 on consecutive cycles.
  - checksum=0x1234 at end (carry dropped).
  - cpu_rst falls exactly RST_HOLD cycles after the last mem_we; running=1.
- load_len=4 with in_valid toggling 1,0,1,0,...:
  - Only accepted words are written, in order, at consecutive addresses.
  - No mem_we on idle cycles.
- BASE_ADDR=0xFFE, load_len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- load_len=0 → no mem_we.
  - HOLD entered directly.
  - cpu_rst released after RST_HOLD cycles; checksum=0.
- Stop in RUN, then load_start with load_len=2:
  - cpu_rst=1 next cycle, running=0.
  - Writes restart at BASE_ADDR; checksum restarts from 0.
- Assert rst low after 2 of 5 words:
  - All outputs immediately at reset values (cpu_rst=1).
  - A new load of 5 words writes from BASE_ADDR and completes normally.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared widths and loader state encodings.
// No logic here; imported by the loader and its write stage.
package program_loader_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_RUN  = 2'd3
   } state_e;

   // A zero-length load skips straight to the reset-hold phase.
   function automatic state_e start_state(input logic zero_len);
      return zero_len ? ST_HOLD : ST_LOAD;
   endfunction

endpackage

// File: rtl/program_loader_write_stage.sv
// Registered memory write port plus running checksum of accepted words.
// One-cycle latency from accept to mem_we; never stalls (no backpressure).
module loader_write_stage
   import program_loader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_vld,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] checksum
);

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] sum_q, sum_d;

   always_comb begin
      we_d   = wr_vld;
      addr_d = addr_q;
      data_d = data_q;
      sum_d  = sum_q;
      if (wr_vld) begin
         addr_d = wr_addr;
         data_d = wr_dat;
      end
      // Sum is registered alongside the write so it moves in the mem_we cycle.
      if (clr) begin
         sum_d = '0;
      end else if (wr_vld) begin
         sum_d = sum_q + wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         sum_q  <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         sum_q  <= sum_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = data_q;
   assign checksum  = sum_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams words into processor memory, then holds cpu_rst RST_HOLD cycles.
// Write lands one cycle after accept; in_ready only in LOAD while words remain.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                RST_HOLD  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              running,
   output logic              busy,
   output logic [DATA_W-1:0] checksum
);

   localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              clr_sum;
   logic              accept;
   logic [ADDR_W-1:0] wr_addr;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      count_d  = count_q;
      hold_d   = hold_q;
      clr_sum  = 1'b0;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (load_start) begin
               len_d   = load_len;
               count_d = '0;
               hold_d  = HOLD_INIT;
               clr_sum = 1'b1;
               state_d = start_state(load_len == '0);
            end
         end
         ST_LOAD: begin
            in_ready = (count_q < len_q);
            if (in_ready && in_valid) begin
               count_d = count_q + (ADDR_W + 1)'(1);
            end
            // count==len only in the cycle the final word is being written.
            if (count_q == len_q) begin
               state_d = ST_HOLD;
               hold_d  = HOLD_INIT;
            end
         end
         ST_HOLD: begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_d == '0) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         count_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         hold_q  <= hold_d;
      end
   end

   assign accept  = in_valid & in_ready;
   assign wr_addr = BASE_ADDR + count_q[ADDR_W-1:0];

   assign cpu_rst = (state_q != ST_RUN);
   assign running = (state_q == ST_RUN);
   assign busy    = (state_q == ST_LOAD) || (state_q == ST_HOLD);

   loader_write_stage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_write_stage (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_sum),
      .wr_vld    (accept),
      .wr_addr   (wr_addr),
      .wr_dat    (in_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .checksum  (checksum)
   );

endmodule
